// File: rtl/instruction_loader.sv
// Byte-stream program loader: frames A5, len_lo, len_hi, data... into instruction memory writes.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instruction_loader #(
   parameter int          DATA_WIDTH                = 32,
   parameter int          INSTRUCTIONMEM_ADDR_WIDTH = 13,
   parameter int unsigned RAM_DEPTH                 = 1 << INSTRUCTIONMEM_ADDR_WIDTH,
   parameter logic [7:0]  START_BYTE                = 8'hA5
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [7:0]                           byteIn,
   input  logic                                 byteValid,
   output logic                                 byteReady,
   output logic                                 writeEnable,
   output logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] writeAddr,
   output logic [DATA_WIDTH-1:0]                writeData,
   output logic                                 cpuHold,
   output logic                                 loadDone,
   output logic                                 loadError
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_CHECK} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE} state_t;
`endif

   state_t                               state;
   logic [7:0]                           len_lo;
   logic [15:0]                          len_n;
   logic [15:0]                          len_full;
   logic [16:0]                          word_cnt;
   logic [INSTRUCTIONMEM_ADDR_WIDTH-1:0] addr;
   logic [IDX_W-1:0]                     byte_idx;
   logic [DATA_WIDTH-1:0]                word_buf;
   logic [DATA_WIDTH-1:0]                merged;
   logic                                 accept;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]                           csum;
`endif

   assign accept   = byteValid && byteReady;
   assign len_full = {byteIn, len_lo};

   // Word as it will look once the current byte lands in its little-endian lane.
   always_comb begin
      merged = word_buf;
      merged[8*byte_idx +: 8] = byteIn;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         byteReady   <= 1'b1;
         writeEnable <= 1'b0;
         writeAddr   <= '0;
         writeData   <= '0;
         cpuHold     <= 1'b0;
         loadDone    <= 1'b0;
         loadError   <= 1'b0;
         len_lo      <= '0;
         len_n       <= '0;
         word_cnt    <= '0;
         addr        <= '0;
         byte_idx    <= '0;
         word_buf    <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum        <= '0;
`endif
      end else begin
         writeEnable <= 1'b0;
         loadDone    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept && byteIn == START_BYTE) begin
                  loadError <= 1'b0;
                  cpuHold   <= 1'b1;
                  addr      <= '0;
                  word_cnt  <= '0;
                  byte_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
                  csum      <= '0;
`endif
                  state     <= S_LEN_LO;
               end
            end
            S_LEN_LO: begin
               if (accept) begin
                  len_lo <= byteIn;
`ifdef LOADER_CHECKSUM_EN
                  csum   <= byteIn;
`endif
                  state  <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept) begin
                  len_n <= len_full;
`ifdef LOADER_CHECKSUM_EN
                  csum  <= csum ^ byteIn;
`endif
                  if ({16'd0, len_full} > RAM_DEPTH) begin
                     loadError <= 1'b1;
                     cpuHold   <= 1'b0;
                     state     <= S_IDLE;
                  end else if (len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     state     <= S_CHECK;
`else
                     state     <= S_DONE;
                     byteReady <= 1'b0;
                     loadDone  <= 1'b1;
                     cpuHold   <= 1'b0;
`endif
                  end else begin
                     state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  word_buf <= merged;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum ^ byteIn;
`endif
                  if (byte_idx == LAST_IDX) begin
                     byte_idx    <= '0;
                     writeData   <= merged;
                     writeAddr   <= addr;
                     writeEnable <= 1'b1;
                     byteReady   <= 1'b0;
                     state       <= S_WRITE;
                  end else begin
                     byte_idx <= byte_idx + 1'b1;
                  end
               end
            end
            S_WRITE: begin
               addr     <= addr + 1'b1;
               word_cnt <= word_cnt + 17'd1;
               byteReady <= 1'b1;
               if (word_cnt + 17'd1 == {1'b0, len_n}) begin
`ifdef LOADER_CHECKSUM_EN
                  state     <= S_CHECK;
`else
                  state     <= S_DONE;
                  byteReady <= 1'b0;
                  loadDone  <= 1'b1;
                  cpuHold   <= 1'b0;
`endif
               end else begin
                  state <= S_DATA;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (accept) begin
                  cpuHold <= 1'b0;
                  if (byteIn == csum) begin
                     state     <= S_DONE;
                     byteReady <= 1'b0;
                     loadDone  <= 1'b1;
                  end else begin
                     loadError <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
`endif
            S_DONE: begin
               byteReady <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               byteReady <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed frames plus randomized frames vs. a frame-parsing model.
// Honours LOADER_CHECKSUM_EN by appending/validating the trailing XOR byte.
module tb_instruction_loader;

   localparam int          DW    = 32;
   localparam int          AW    = 13;
   localparam int          BYTES = DW / 8;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset;
   logic [7:0]    byteIn;
   logic          byteValid;
   logic          byteReady;
   logic          writeEnable;
   logic [AW-1:0] writeAddr;
   logic [DW-1:0] writeData;
   logic          cpuHold;
   logic          loadDone;
   logic          loadError;

   instruction_loader #(
      .DATA_WIDTH(DW),
      .INSTRUCTIONMEM_ADDR_WIDTH(AW)
   ) dut (
      .clock(clock), .reset(reset), .byteIn(byteIn), .byteValid(byteValid),
      .byteReady(byteReady), .writeEnable(writeEnable), .writeAddr(writeAddr),
      .writeData(writeData), .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [AW-1:0] got_addr[$];
   logic [DW-1:0] got_data[$];
   int            done_cnt;
   int            hold_bad;

   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] exp_data[$];
   int            exp_done;
   logic          exp_err;

   logic [7:0]    frame[$];

   always @(negedge clock) begin
      if (!reset) begin
         if (writeEnable) begin
            got_addr.push_back(writeAddr);
            got_data.push_back(writeData);
            if (!cpuHold) hold_bad++;
         end
         if (loadDone) done_cnt++;
      end
   end

   task automatic clear_obs();
      got_addr.delete(); got_data.delete();
      exp_addr.delete(); exp_data.delete();
      done_cnt = 0; hold_bad = 0; exp_done = 0; exp_err = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int t;
      byteValid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clock);
      byteValid = 1'b1;
      byteIn    = b;
      t = 0;
      while (!byteReady && t < 200) begin
         @(negedge clock);
         t++;
      end
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL handshake_timeout byte %02h: byteReady stayed 0, required 1", b);
      end
      @(negedge clock);
      byteValid = 1'b0;
   endtask

   task automatic idle(input int n);
      byteValid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic add_csum();
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] cs;
      bit started;
      cs = 8'h00; started = 0;
      foreach (frame[i]) begin
         if (started) cs ^= frame[i];
         else if (frame[i] == 8'hA5) started = 1;
      end
      frame.push_back(cs);
`endif
   endtask

   // Reference: parse the frame as a byte list and derive the writes/result it should produce.
   task automatic model_frame();
      int i, n;
      logic [7:0]    cs;
      logic [DW-1:0] w;
      i = 0;
      while (i < frame.size() && frame[i] != 8'hA5) i++;
      if (i + 2 >= frame.size()) return;
      n  = int'(frame[i+1]) + 256 * int'(frame[i+2]);
      cs = frame[i+1] ^ frame[i+2];
      if (n > int'(DEPTH)) begin
         exp_err = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         w = '0;
         for (int b = 0; b < BYTES; b++) begin
            w  = w | (DW'(frame[i + 3 + k*BYTES + b]) << (8*b));
            cs = cs ^ frame[i + 3 + k*BYTES + b];
         end
         exp_addr.push_back(AW'(k));
         exp_data.push_back(w);
      end
`ifdef LOADER_CHECKSUM_EN
      if (frame[i + 3 + n*BYTES] == cs) exp_done = 1;
      else exp_err = 1'b1;
`else
      exp_done = 1;
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1; byteValid = 1'b0; byteIn = 8'h00;
      repeat (3) @(negedge clock);
      checks++;
      if ({byteReady, writeEnable, cpuHold, loadDone, loadError} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl got %b required 10000", {byteReady, writeEnable, cpuHold, loadDone, loadError});
      end
      checks++;
      if (writeAddr !== '0 || writeData !== '0) begin
         errors++;
         $display("FAIL reset_bus got addr %h data %h required 0/0", writeAddr, writeData);
      end
      reset = 1'b0;
      idle(2);
   endtask

   task automatic test_two_word(input bit garbage);
      clear_obs();
      frame = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      add_csum();
      if (garbage) begin
         send_byte(8'h00, 2); send_byte(8'hFF, 2); send_byte(8'h13, 2);
      end
      foreach (frame[i]) begin
         send_byte(frame[i], garbage ? 3 : 0);
         if (i == 0) begin
            checks++;
            if (cpuHold !== 1'b1) begin
               errors++; $display("FAIL hold_after_start got %b required 1", cpuHold);
            end
         end
         if (i == 5) begin
            checks++;
            if (got_addr.size() != 0) begin
               errors++; $display("FAIL early_write got %0d writes required 0", got_addr.size());
            end
         end
      end
      idle(8);
      checks++;
      if (got_addr.size() != 2) begin
         errors++; $display("FAIL two_word_count got %0d required 2", got_addr.size());
      end else begin
         checks++;
         if ({got_addr[0], got_data[0]} !== {13'd0, 32'h12345678}) begin
            errors++; $display("FAIL word0 got %h@%h required 12345678@0", got_data[0], got_addr[0]);
         end
         checks++;
         if ({got_addr[1], got_data[1]} !== {13'd1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL word1 got %h@%h required deadbeef@1", got_data[1], got_addr[1]);
         end
      end
      checks++;
      if (done_cnt != 1 || loadError !== 1'b0 || cpuHold !== 1'b0 || hold_bad != 0) begin
         errors++;
         $display("FAIL two_word_status got done=%0d err=%b hold=%b holdbad=%0d required 1/0/0/0",
                  done_cnt, loadError, cpuHold, hold_bad);
      end
   endtask

   task automatic test_zero_len();
      clear_obs();
      frame = '{8'hA5, 8'h00, 8'h00};
      add_csum();
      foreach (frame[i]) send_byte(frame[i], 1);
      idle(6);
      checks++;
      if (got_addr.size() != 0 || done_cnt != 1 || loadError !== 1'b0 || cpuHold !== 1'b0) begin
         errors++;
         $display("FAIL zero_len got writes=%0d done=%0d err=%b hold=%b required 0/1/0/0",
                  got_addr.size(), done_cnt, loadError, cpuHold);
      end
   endtask

   task automatic test_oversize();
      clear_obs();
      frame = '{8'hA5, 8'h01, 8'h20};
      foreach (frame[i]) send_byte(frame[i], 0);
      idle(6);
      checks++;
      if (got_addr.size() != 0 || done_cnt != 0 || loadError !== 1'b1 || cpuHold !== 1'b0) begin
         errors++;
         $display("FAIL oversize got writes=%0d done=%0d err=%b hold=%b required 0/0/1/0",
                  got_addr.size(), done_cnt, loadError, cpuHold);
      end
      clear_obs();
      frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      add_csum();
      foreach (frame[i]) send_byte(frame[i], 1);
      idle(6);
      checks++;
      if (got_addr.size() != 1 || done_cnt != 1 || loadError !== 1'b0) begin
         errors++;
         $display("FAIL after_oversize got writes=%0d done=%0d err=%b required 1/1/0",
                  got_addr.size(), done_cnt, loadError);
      end else begin
         checks++;
         if ({got_addr[0], got_data[0]} !== {13'd0, 32'h44332211}) begin
            errors++; $display("FAIL after_oversize_word got %h@%h required 44332211@0", got_data[0], got_addr[0]);
         end
      end
   endtask

   task automatic test_reset_midload();
      clear_obs();
      frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      foreach (frame[i]) send_byte(frame[i], 0);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({byteReady, writeEnable, cpuHold, loadDone, loadError} !== 5'b10000 || writeAddr !== '0 || writeData !== '0) begin
         errors++;
         $display("FAIL midload_reset got ctrl=%b addr=%h data=%h required 10000/0/0",
                  {byteReady, writeEnable, cpuHold, loadDone, loadError}, writeAddr, writeData);
      end
      reset = 1'b0;
      idle(3);
      checks++;
      if (got_addr.size() != 0) begin
         errors++; $display("FAIL midload_nowrite got %0d writes required 0", got_addr.size());
      end
      frame = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      add_csum();
      foreach (frame[i]) send_byte(frame[i], 1);
      idle(6);
      checks++;
      if (got_addr.size() != 1 || done_cnt != 1) begin
         errors++; $display("FAIL restart_count got writes=%0d done=%0d required 1/1", got_addr.size(), done_cnt);
      end else begin
         checks++;
         if ({got_addr[0], got_data[0]} !== {13'd0, 32'hDDCCBBAA}) begin
            errors++; $display("FAIL restart_word got %h@%h required ddccbbaa@0", got_data[0], got_addr[0]);
         end
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      for (int pass = 0; pass < 2; pass++) begin
         clear_obs();
         frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
         frame.push_back(pass == 0 ? 8'h45 : 8'h00);
         foreach (frame[i]) send_byte(frame[i], 1);
         idle(6);
         checks++;
         if (got_addr.size() != 1 || got_data[0] !== 32'h44332211 || got_addr[0] !== '0) begin
            errors++; $display("FAIL csum_write pass %0d got %0d writes required 1 of 44332211@0", pass, got_addr.size());
         end
         checks++;
         if (done_cnt != (pass == 0 ? 1 : 0) || loadError !== (pass == 0 ? 1'b0 : 1'b1) || cpuHold !== 1'b0) begin
            errors++;
            $display("FAIL csum_status pass %0d got done=%0d err=%b hold=%b", pass, done_cnt, loadError, cpuHold);
         end
      end
   endtask
`endif

   task automatic test_random();
      int n;
      logic [7:0] g;
      for (int it = 0; it < 25; it++) begin
         clear_obs();
         frame.delete();
         repeat ($urandom_range(3, 0)) begin
            g = 8'($urandom_range(255, 0));
            if (g == 8'hA5) g = 8'h5A;
            frame.push_back(g);
         end
         n = $urandom_range(5, 0);
         frame.push_back(8'hA5);
         frame.push_back(8'(n));
         frame.push_back(8'h00);
         repeat (n * BYTES) frame.push_back(8'($urandom_range(255, 0)));
         add_csum();
`ifdef LOADER_CHECKSUM_EN
         if ($urandom_range(3, 0) == 0) frame[frame.size()-1] = ~frame[frame.size()-1];
`endif
         model_frame();
         foreach (frame[i]) send_byte(frame[i], 2);
         idle(8);
         checks++;
         if (got_addr.size() != exp_addr.size()) begin
            errors++;
            $display("FAIL rand_count iter %0d got %0d required %0d", it, got_addr.size(), exp_addr.size());
         end else begin
            foreach (exp_addr[k]) begin
               checks++;
               if ({got_addr[k], got_data[k]} !== {exp_addr[k], exp_data[k]}) begin
                  errors++;
                  $display("FAIL rand_word iter %0d k %0d got %h@%h required %h@%h",
                           it, k, got_data[k], got_addr[k], exp_data[k], exp_addr[k]);
               end
            end
         end
         checks++;
         if (done_cnt != exp_done || loadError !== exp_err || cpuHold !== 1'b0 || hold_bad != 0) begin
            errors++;
            $display("FAIL rand_status iter %0d got done=%0d err=%b hold=%b holdbad=%0d required %0d/%b/0/0",
                     it, done_cnt, loadError, cpuHold, hold_bad, exp_done, exp_err);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_two_word(1'b0);
      test_two_word(1'b1);
      test_zero_len();
      test_oversize();
      test_reset_midload();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
